byte_reorder_stream: RTL



---
 rtl/byte_reorder_stream.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/byte_reorder_stream.sv
// Streaming byte/bit reorder stage: per-packet mode lock, output register plus
// one-entry skid buffer, and a saturating accepted-beat counter.
module byte_reorder_stream #(
  parameter int NBYTES = 4,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [1:0]          mode_i,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [8*NBYTES-1:0] in_data,
  input  logic                in_last,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [8*NBYTES-1:0] out_data,
  output logic                out_last,
  output logic [1:0]          out_mode,
  input  logic                clr_count,
  output logic [CNT_W-1:0]    word_count
);
  localparam int W = 8 * NBYTES;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [0:0] {IDLE = 1'b0, IN_PKT = 1'b1} state_t;

  function automatic logic [W-1:0] reorder(input logic [W-1:0] d, input logic [1:0] m);
    logic [W-1:0] r;
    r = d;
    case (m)
      2'd0: r = d;
      2'd1: for (int k = 0; k < NBYTES; k++) r[8*k +: 8] = d[8*(NBYTES-1-k) +: 8];
      2'd2: for (int k = 0; k < NBYTES; k++) r[8*k +: 8] = d[8*(k ^ 1) +: 8];
      2'd3: for (int k = 0; k < NBYTES; k++)
              for (int b = 0; b < 8; b++) r[8*k + b] = d[8*k + 7 - b];
      default: r = d;
    endcase
    return r;
  endfunction

  state_t           state_r;
  logic [1:0]       pkt_mode_r;
  logic             in_ready_r;
  logic             out_valid_r, out_last_r, skid_valid_r, skid_last_r;
  logic [W-1:0]     out_data_r, skid_data_r;
  logic [1:0]       out_mode_r, skid_mode_r;
  logic [CNT_W-1:0] word_count_r;

  logic             accept_s, xfer_s;
  logic [1:0]       eff_mode_s;
  logic [W-1:0]     beat_data_s;

  // Handshake decode and transform of the incoming beat under the effective mode
  always_comb begin
    accept_s = in_valid && in_ready_r;
    xfer_s   = out_valid_r && out_ready;
    if (state_r == IN_PKT) begin
      eff_mode_s = pkt_mode_r;
    end else begin
      eff_mode_s = mode_i;
    end
    beat_data_s = reorder(in_data, eff_mode_s);
  end

  // Output register and skid; in_ready is the registered inverse of skid occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r  <= 1'b0;
      out_data_r   <= '0;
      out_last_r   <= 1'b0;
      out_mode_r   <= 2'd0;
      skid_valid_r <= 1'b0;
      skid_data_r  <= '0;
      skid_last_r  <= 1'b0;
      skid_mode_r  <= 2'd0;
      in_ready_r   <= 1'b1;
    end else if (!out_valid_r || xfer_s) begin
      if (skid_valid_r) begin
        out_valid_r  <= 1'b1;
        out_data_r   <= skid_data_r;
        out_last_r   <= skid_last_r;
        out_mode_r   <= skid_mode_r;
        skid_valid_r <= 1'b0;
        in_ready_r   <= 1'b1;
      end else if (accept_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= beat_data_s;
        out_last_r  <= in_last;
        out_mode_r  <= eff_mode_s;
      end else begin
        out_valid_r <= 1'b0;
      end
    end else if (accept_s) begin
      // Output is stalled: park the new beat so the held output stays stable
      skid_valid_r <= 1'b1;
      skid_data_r  <= beat_data_s;
      skid_last_r  <= in_last;
      skid_mode_r  <= eff_mode_s;
      in_ready_r   <= 1'b0;
    end
  end

  // Packet FSM: lock the mode on the first beat of each packet
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      pkt_mode_r <= 2'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            pkt_mode_r <= mode_i;
            if (!in_last) state_r <= IN_PKT;
          end
        end
        IN_PKT: begin
          if (accept_s && in_last) state_r <= IDLE;
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  // Saturating accepted-beat counter with synchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_count_r <= '0;
    end else if (clr_count) begin
      word_count_r <= accept_s ? CNT_ONE : '0;
    end else if (accept_s && (word_count_r != CNT_MAX)) begin
      word_count_r <= word_count_r + CNT_ONE;
    end
  end

  assign in_ready   = in_ready_r;
  assign out_valid  = out_valid_r;
  assign out_data   = out_data_r;
  assign out_last   = out_last_r;
  assign out_mode   = out_mode_r;
  assign word_count = word_count_r;

endmodule
